simd_decode_queue: RTL and testbench

- Parametrised successor to the single-instruction SIMD decoder. Decodes one instruction per cycle into control bundles and stores them in a 2-entry output queue.
- Uses valid/ready handshakes on input and output, so fetch and execute can stall independently.
- Adds illegal-opcode flagging, a halt-on-RET state, flush, and a decoded-instruction counter.
- Sits between the fetch stage and the per-lane execute/register-file stage.

---
 rtl/simd_decode_queue.sv | 179 +++++++++++++++++
 tb/tb_simd_decode_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_decode_queue.sv
// simd_decode_queue
//   Decodes one SIMD instruction per cycle into a control bundle and holds
//   up to two decoded bundles for the execute stage.
//
//   Handshakes (both sides): a transfer happens on a rising clock edge where
//   valid && ready are both high. valid, once raised by a producer, is not
//   expected to depend on ready; ready may depend on valid.
//     input side : in_valid / in_ready   (accept = in_valid && in_ready)
//     output side: out_valid / out_ready (pop    = out_valid && out_ready)
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     flush               empty the queue, return to RUN
//     in_valid/in_ready   instruction handshake; instruction = raw word
//     out_valid/out_ready head bundle handshake
//     reg_write, mem_read, mem_write, reg_write_mux, alu_op, ret, illegal,
//     rd, rm, rn, imm     head bundle fields
//     halted              state == HALTED (FSM state exposure)
//     decode_count        number of accepted instructions (wraps)
module simd_decode_queue #(
  parameter int INSTR_W      = 32,
  parameter int OP_W         = 6,
  parameter int REG_IDX_W    = 7,
  parameter int IMM_W        = INSTR_W - OP_W - REG_IDX_W,
  parameter int DATA_W       = 32,
  parameter int SIGN_EXT_IMM = 0,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   instruction,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [1:0]           reg_write_mux,
  output logic [2:0]           alu_op,
  output logic                 ret,
  output logic                 illegal,
  output logic [REG_IDX_W-1:0] rd,
  output logic [REG_IDX_W-1:0] rm,
  output logic [REG_IDX_W-1:0] rn,
  output logic [DATA_W-1:0]    imm,
  output logic                 halted,
  output logic [CNT_W-1:0]     decode_count
);

  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(6'h01);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(6'h03);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(6'h05);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(6'h06);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(6'h07);
  localparam logic [OP_W-1:0] OP_ORR   = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_CONST = OP_W'(6'h09);
  localparam logic [OP_W-1:0] OP_CMP   = OP_W'(6'h0A);
  localparam logic [OP_W-1:0] OP_RET   = OP_W'(6'h3F);

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic [1:0]           reg_write_mux;
    logic [2:0]           alu_op;
    logic                 ret;
    logic                 illegal;
    logic [REG_IDX_W-1:0] rd;
    logic [REG_IDX_W-1:0] rm;
    logic [REG_IDX_W-1:0] rn;
    logic [DATA_W-1:0]    imm;
  } bundle_t;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t     state;
  bundle_t    q0;      // head entry
  bundle_t    q1;      // second entry
  logic [1:0] count;
  bundle_t    dec;
  logic       push;
  logic       pop;

  logic [OP_W-1:0]   opcode;
  logic [IMM_W-1:0]  imm_raw;
  logic              imm_sign;
  logic [DATA_W-1:0] imm_ext;

  assign opcode   = instruction[INSTR_W-1 -: OP_W];
  assign imm_raw  = instruction[IMM_W-1:0];
  assign imm_sign = (SIGN_EXT_IMM != 0) && imm_raw[IMM_W-1];
  assign imm_ext  = {{(DATA_W-IMM_W){imm_sign}}, imm_raw};

  always_comb begin
    dec    = '0;
    dec.rd = instruction[INSTR_W-OP_W-1 -: REG_IDX_W];
    dec.rm = instruction[INSTR_W-OP_W-REG_IDX_W-1 -: REG_IDX_W];
    dec.rn = instruction[INSTR_W-OP_W-2*REG_IDX_W-1 -: REG_IDX_W];
    case (opcode)
      OP_NOP:   ;
      OP_LOAD:  begin dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.reg_write_mux = 2'd1; end
      OP_STORE: dec.mem_write = 1'b1;
      OP_ADD:   begin dec.reg_write = 1'b1; dec.alu_op = 3'd0; end
      OP_SUB:   begin dec.reg_write = 1'b1; dec.alu_op = 3'd1; end
      OP_MUL:   begin dec.reg_write = 1'b1; dec.alu_op = 3'd2; end
      OP_DIV:   begin dec.reg_write = 1'b1; dec.alu_op = 3'd3; end
      OP_AND:   begin dec.reg_write = 1'b1; dec.alu_op = 3'd4; end
      OP_ORR:   begin dec.reg_write = 1'b1; dec.alu_op = 3'd5; end
      OP_CMP:   begin dec.reg_write = 1'b1; dec.alu_op = 3'd6; end
      OP_CONST: begin dec.reg_write = 1'b1; dec.reg_write_mux = 2'd2; dec.imm = imm_ext; end
      OP_RET:   dec.ret = 1'b1;
      default:  dec.illegal = 1'b1;
    endcase
  end

  assign pop      = (count != 2'd0) && out_ready;
  // A full queue can still take a new word when its head leaves this cycle.
  assign in_ready = (state == RUN) && ((count < 2'd2) || pop);
  // flush wins over any same-cycle transfer on either side.
  assign push     = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      q0           <= '0;
      q1           <= '0;
      count        <= 2'd0;
      decode_count <= '0;
    end else if (flush) begin
      state <= RUN;
      count <= 2'd0;
    end else begin
      if (push) begin
        decode_count <= decode_count + CNT_W'(1);
        if (dec.ret) state <= HALTED;
      end
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) q0 <= dec;
          else               q1 <= dec;
          count <= count + 2'd1;
        end
        2'b01: begin
          q0    <= q1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            q0 <= dec;
          end else begin
            q0 <= q1;
            q1 <= dec;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid     = (count != 2'd0);
  assign reg_write     = q0.reg_write;
  assign mem_read      = q0.mem_read;
  assign mem_write     = q0.mem_write;
  assign reg_write_mux = q0.reg_write_mux;
  assign alu_op        = q0.alu_op;
  assign ret           = q0.ret;
  assign illegal       = q0.illegal;
  assign rd            = q0.rd;
  assign rm            = q0.rm;
  assign rn            = q0.rn;
  assign imm           = q0.imm;
  assign halted        = (state == HALTED);

endmodule

// File: tb/tb_simd_decode_queue.sv
// Bench for simd_decode_queue: a zero-extending and a sign-extending instance
// share every input; single-instruction decode vectors come from a table,
// queueing / halt / flush / reset behaviour from hand-written sequences.
module tb_simd_decode_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic        reg_write, mem_read, mem_write, ret, illegal, halted;
  logic [1:0]  reg_write_mux;
  logic [2:0]  alu_op;
  logic [6:0]  rd, rm, rn;
  logic [31:0] imm;
  logic [15:0] decode_count;

  logic        in_ready_s, out_valid_s;
  logic        reg_write_s, mem_read_s, mem_write_s, ret_s, illegal_s, halted_s;
  logic [1:0]  reg_write_mux_s;
  logic [2:0]  alu_op_s;
  logic [6:0]  rd_s, rm_s, rn_s;
  logic [31:0] imm_s;
  logic [15:0] decode_count_s;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  simd_decode_queue #(.SIGN_EXT_IMM(0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write_mux(reg_write_mux), .alu_op(alu_op), .ret(ret), .illegal(illegal),
    .rd(rd), .rm(rm), .rn(rn), .imm(imm),
    .halted(halted), .decode_count(decode_count)
  );

  simd_decode_queue #(.SIGN_EXT_IMM(1)) dut_s (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .instruction(instruction),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .reg_write(reg_write_s), .mem_read(mem_read_s), .mem_write(mem_write_s),
    .reg_write_mux(reg_write_mux_s), .alu_op(alu_op_s), .ret(ret_s), .illegal(illegal_s),
    .rd(rd_s), .rm(rm_s), .rn(rn_s), .imm(imm_s),
    .halted(halted_s), .decode_count(decode_count_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        rw, mr, mw;
    logic [1:0]  mux;
    logic [2:0]  alu;
    logic        rt, il;
    logic [6:0]  rd, rm, rn;
    logic [31:0] imm0, imm1;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [6:0] d,
                                     input logic [6:0] m, input logic [6:0] n);
    return {op, d, m, n, 5'd0};
  endfunction

  function automatic vec_t v(input string n, input logic [31:0] i,
                             input logic rw, input logic mr, input logic mw,
                             input logic [1:0] mux, input logic [2:0] alu,
                             input logic rt, input logic il,
                             input logic [6:0] d, input logic [6:0] m, input logic [6:0] r,
                             input logic [31:0] i0, input logic [31:0] i1);
    vec_t x;
    x.name = n; x.instr = i; x.rw = rw; x.mr = mr; x.mw = mw; x.mux = mux;
    x.alu = alu; x.rt = rt; x.il = il; x.rd = d; x.rm = m; x.rn = r;
    x.imm0 = i0; x.imm1 = i1;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bundle(input vec_t x);
    check({x.name, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    check({x.name, ".ctrl"}, {24'd0, reg_write, mem_read, mem_write, ret, illegal, 3'd0},
          {24'd0, x.rw, x.mr, x.mw, x.rt, x.il, 3'd0});
    check({x.name, ".mux"}, {30'd0, reg_write_mux}, {30'd0, x.mux});
    check({x.name, ".alu_op"}, {29'd0, alu_op}, {29'd0, x.alu});
    check({x.name, ".regs"}, {11'd0, rd, rm, rn}, {11'd0, x.rd, x.rm, x.rn});
    check({x.name, ".imm_zext"}, imm, x.imm0);
    check({x.name, ".imm_sext"}, imm_s, x.imm1);
  endtask

  initial begin
    vec_t ret_v;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instruction = '0; out_ready = 1'b0;

    vecs[0]  = v("ADD",   mk(6'h03, 7'd5, 7'd6, 7'd7),      1,0,0,2'd0,3'd0,0,0, 7'd5, 7'd6, 7'd7, 0, 0);
    vecs[1]  = v("SUB",   mk(6'h04, 7'd1, 7'd2, 7'd3),      1,0,0,2'd0,3'd1,0,0, 7'd1, 7'd2, 7'd3, 0, 0);
    vecs[2]  = v("MUL",   mk(6'h05, 7'd10, 7'd20, 7'd30),   1,0,0,2'd0,3'd2,0,0, 7'd10, 7'd20, 7'd30, 0, 0);
    vecs[3]  = v("DIV",   mk(6'h06, 7'd127, 7'd0, 7'd64),   1,0,0,2'd0,3'd3,0,0, 7'd127, 7'd0, 7'd64, 0, 0);
    vecs[4]  = v("AND",   mk(6'h07, 7'd8, 7'd9, 7'd10),     1,0,0,2'd0,3'd4,0,0, 7'd8, 7'd9, 7'd10, 0, 0);
    vecs[5]  = v("ORR",   mk(6'h08, 7'd11, 7'd12, 7'd13),   1,0,0,2'd0,3'd5,0,0, 7'd11, 7'd12, 7'd13, 0, 0);
    vecs[6]  = v("CMP",   mk(6'h0A, 7'd14, 7'd15, 7'd16),   1,0,0,2'd0,3'd6,0,0, 7'd14, 7'd15, 7'd16, 0, 0);
    vecs[7]  = v("LOAD",  mk(6'h01, 7'd4, 7'd100, 7'd0),    1,1,0,2'd1,3'd0,0,0, 7'd4, 7'd100, 7'd0, 0, 0);
    vecs[8]  = v("STORE", mk(6'h02, 7'd0, 7'd3, 7'd99),     0,0,1,2'd0,3'd0,0,0, 7'd0, 7'd3, 7'd99, 0, 0);
    vecs[9]  = v("NOP",   mk(6'h00, 7'd1, 7'd1, 7'd1),      0,0,0,2'd0,3'd0,0,0, 7'd1, 7'd1, 7'd1, 0, 0);
    vecs[10] = v("ILL2A", mk(6'h2A, 7'd2, 7'd3, 7'd4),      0,0,0,2'd0,3'd0,0,1, 7'd2, 7'd3, 7'd4, 0, 0);
    vecs[11] = v("CONSTmax", {6'h09, 7'd3, 19'h7FFFF},      1,0,0,2'd2,3'd0,0,0, 7'd3, 7'h7F, 7'h7F,
                 32'h0007FFFF, 32'hFFFFFFFF);
    vecs[12] = v("CONSTpos", {6'h09, 7'd9, 19'h12345},      1,0,0,2'd2,3'd0,0,0, 7'd9, 7'h12, 7'h1A,
                 32'h00012345, 32'h00012345);
    vecs[13] = v("CONSTmsb", {6'h09, 7'd0, 19'h40000},      1,0,0,2'd2,3'd0,0,0, 7'd0, 7'h40, 7'h00,
                 32'h00040000, 32'hFFFC0000);
    vecs[14] = v("ILL3E", mk(6'h3E, 7'd0, 7'd0, 7'd0),      0,0,0,2'd0,3'd0,0,1, 7'd0, 7'd0, 7'd0, 0, 0);
    vecs[15] = v("ILL0B", mk(6'h0B, 7'd50, 7'd60, 7'd70),   0,0,0,2'd0,3'd0,0,1, 7'd50, 7'd60, 7'd70, 0, 0);
    ret_v    = v("RET",   mk(6'h3F, 7'd1, 7'd2, 7'd3),      0,0,0,2'd0,3'd0,1,0, 7'd1, 7'd2, 7'd3, 0, 0);

    // reset state
    step(); step();
    rst = 1'b0;
    #1;
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.halted", {31'd0, halted}, 32'd0);
    check("rst.decode_count", {16'd0, decode_count}, 32'd0);
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.bundle", {23'd0, reg_write, mem_read, mem_write, reg_write_mux, alu_op, ret, illegal}, 32'd0);
    check("rst.imm", imm, 32'd0);

    // single-instruction decode table
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; instruction = vecs[i].instr; out_ready = 1'b1;
      #1;
      check({vecs[i].name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      exp_cnt++;
      chk_bundle(vecs[i]);
      check({vecs[i].name, ".halted"}, {31'd0, halted}, 32'd0);
      step();
      check({vecs[i].name, ".drained"}, {31'd0, out_valid}, 32'd0);
    end
    check("table.decode_count", {16'd0, decode_count}, exp_cnt);

    // backpressure: queue fills at two, SUB is held, then FIFO order
    out_ready = 1'b0; in_valid = 1'b1; instruction = vecs[7].instr;
    #1; check("bp.ready0", {31'd0, in_ready}, 32'd1);
    step(); exp_cnt++;
    instruction = vecs[8].instr;
    #1; check("bp.ready1", {31'd0, in_ready}, 32'd1);
    step(); exp_cnt++;
    instruction = vecs[1].instr;
    #1; check("bp.full_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("bp.held_ready", {31'd0, in_ready}, 32'd0);
    check("bp.held_count", {16'd0, decode_count}, exp_cnt);
    chk_bundle(vecs[7]);
    out_ready = 1'b1;
    #1; check("bp.pop_ready", {31'd0, in_ready}, 32'd1);
    step(); exp_cnt++;
    in_valid = 1'b0;
    chk_bundle(vecs[8]);
    step();
    chk_bundle(vecs[1]);
    step();
    check("bp.empty", {31'd0, out_valid}, 32'd0);
    check("bp.decode_count", {16'd0, decode_count}, exp_cnt);

    // RET halts; following ADD is refused; flush resumes
    out_ready = 1'b0; in_valid = 1'b1; instruction = ret_v.instr;
    step(); exp_cnt++;
    instruction = vecs[0].instr;
    #1;
    chk_bundle(ret_v);
    check("ret.halted", {31'd0, halted}, 32'd1);
    check("ret.in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("ret.add_refused", {16'd0, decode_count}, exp_cnt);
    check("ret.still_one", {31'd0, out_valid & ret}, 32'd1);
    out_ready = 1'b1;
    step();
    check("ret.drained", {31'd0, out_valid}, 32'd0);
    check("ret.halted_after_drain", {31'd0, halted}, 32'd1);
    check("ret.ready_after_drain", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("flush.halted", {31'd0, halted}, 32'd0);
    check("flush.in_ready", {31'd0, in_ready}, 32'd1);
    check("flush.out_valid", {31'd0, out_valid}, 32'd0);
    check("flush.decode_count", {16'd0, decode_count}, exp_cnt);

    // flush with a full queue and a same-cycle instruction and pop
    out_ready = 1'b0; in_valid = 1'b1; instruction = vecs[0].instr;
    step(); exp_cnt++;
    instruction = vecs[1].instr;
    step(); exp_cnt++;
    check("fq.full_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1; instruction = vecs[2].instr; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fq.out_valid", {31'd0, out_valid}, 32'd0);
    check("fq.decode_count", {16'd0, decode_count}, exp_cnt);
    step();
    check("fq.stays_empty", {31'd0, out_valid}, 32'd0);
    check("fq.in_ready", {31'd0, in_ready}, 32'd1);

    // reset with a full, halted queue
    out_ready = 1'b0; in_valid = 1'b1; instruction = vecs[11].instr;
    step(); exp_cnt++;
    instruction = ret_v.instr;
    step(); exp_cnt++;
    in_valid = 1'b0;
    check("pre_rst.halted", {31'd0, halted}, 32'd1);
    check("pre_rst.decode_count", {16'd0, decode_count}, exp_cnt);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mid_rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst.halted", {31'd0, halted}, 32'd0);
    check("mid_rst.decode_count", {16'd0, decode_count}, 32'd0);
    check("mid_rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst.bundle", {23'd0, reg_write, mem_read, mem_write, reg_write_mux, alu_op, ret, illegal}, 32'd0);
    check("mid_rst.regs", {11'd0, rd, rm, rn}, 32'd0);
    check("mid_rst.imm", imm, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
